fetch_sequencer: RTL and testbench

Instruction-fetch controller for the 5-stage pipeline: owns the program counter, drives the address of the byte-addressed instruction memory (16-bit big-endian instructions, combinational read), and loads the IF/ID register. It arbitrates the next-PC sources (sequential, branch redirect, exception vector, exception return), applies hazard stalls, inserts bubbles on redirects, and halts on fetch faults or nested exceptions.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_next_pc.sv | 51 +++++
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
package fetch_pkg;

  // Fetch FSM: RUN fetches; HALT is sticky until reset.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Next-PC source chosen by the priority encoder.
  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    BRANCH = 3'd1,
    VECTOR = 3'd2,
    ERET   = 3'd3,
    HOLD   = 3'd4
  } npc_sel_t;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC priority encoder: picks the PC source, raises flush
// on redirects and flags fetch faults / nested exceptions.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int MEM_BYTES = 100
) (
  input  logic        run,
  input  logic        in_handler,
  input  logic        exc_req,
  input  logic        eret,
  input  logic        branch_taken,
  input  logic        stall,
  input  logic [15:0] pc,
  output npc_sel_t    sel,
  output logic        flush,
  output logic        fetch_fault,
  output logic        nested_exc
);

  // Highest priority first; redirects win over stall. Range check only
  // applies to a sequential load, so redirect targets are checked once
  // they have become the PC.
  always_comb begin
    sel         = HOLD;
    flush       = 1'b0;
    fetch_fault = 1'b0;
    nested_exc  = 1'b0;
    if (run) begin
      if (exc_req && in_handler) begin
        nested_exc = 1'b1;
        flush      = 1'b1;
      end else if (exc_req) begin
        sel   = VECTOR;
        flush = 1'b1;
      end else if (eret && in_handler) begin
        sel   = ERET;
        flush = 1'b1;
      end else if (branch_taken) begin
        sel   = BRANCH;
        flush = 1'b1;
      end else if (stall) begin
        sel = HOLD;
      end else begin
        sel         = SEQ;
        fetch_fault = pc[0] || (({1'b0, pc} + 17'd1) >= 17'(MEM_BYTES));
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC register, IF/ID register, exception
// bookkeeping and the RUN/HALT FSM.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          MEM_BYTES  = 100,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0040
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        exc_req,
  input  logic [15:0] exc_pc,
  input  logic        eret,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic        flush,
  output logic [15:0] epc,
  output logic        in_handler,
  output logic        halted,
  output logic        fault
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc;
  npc_sel_t     sel;
  logic         fetch_fault;
  logic         nested_exc;

  fetch_next_pc #(.MEM_BYTES(MEM_BYTES)) u_npc (
    .run          (state_q == RUN),
    .in_handler   (in_handler),
    .exc_req      (exc_req),
    .eret         (eret),
    .branch_taken (branch_taken),
    .stall        (stall),
    .pc           (pc),
    .sel          (sel),
    .flush        (flush),
    .fetch_fault  (fetch_fault),
    .nested_exc   (nested_exc)
  );

  assign imem_addr = pc;
  assign halted    = (state_q == HALT);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: a bad fetch or a nested exception stops fetch for good.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && (fetch_fault || nested_exc)) state_d = HALT;
  end

  // PC, IF/ID and exception registers. Halting and redirects leave a bubble
  // in IF/ID (if_pc untouched); in HALT sel is HOLD so everything freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      if_instr   <= NOP_INSTR;
      if_pc      <= 16'h0000;
      if_valid   <= 1'b0;
      epc        <= 16'h0000;
      in_handler <= 1'b0;
      fault      <= 1'b0;
    end else if (nested_exc) begin
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else begin
      unique case (sel)
        VECTOR: begin
          epc        <= exc_pc;
          in_handler <= 1'b1;
          pc         <= EXC_VECTOR;
          if_instr   <= NOP_INSTR;
          if_valid   <= 1'b0;
        end
        ERET: begin
          pc         <= epc;
          in_handler <= 1'b0;
          if_instr   <= NOP_INSTR;
          if_valid   <= 1'b0;
        end
        BRANCH: begin
          pc       <= branch_target;
          if_instr <= NOP_INSTR;
          if_valid <= 1'b0;
        end
        SEQ: begin
          if (fetch_fault) begin
            fault    <= 1'b1;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
          end else begin
            if_instr <= imem_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 16'd2;
          end
        end
        default: ; // HOLD
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// traffic, all compared against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam int          MEMB = 100;
  localparam logic [15:0] EXCV = 16'h0040;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr, imem_data;
  logic        stall, branch_taken, exc_req, eret;
  logic [15:0] branch_target, exc_pc;
  logic [15:0] if_instr, if_pc, epc;
  logic        if_valid, flush, in_handler, halted, fault;

  fetch_sequencer #(.MEM_BYTES(MEMB), .RESET_PC(16'h0000), .EXC_VECTOR(EXCV)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .exc_req(exc_req), .exc_pc(exc_pc), .eret(eret), .if_instr(if_instr),
    .if_pc(if_pc), .if_valid(if_valid), .flush(flush), .epc(epc),
    .in_handler(in_handler), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Byte-wide memory, big-endian 16-bit reads, combinational.
  logic [7:0] mem [0:MEMB-1];
  always_comb begin
    if (int'(imem_addr) < MEMB - 1)
      imem_data = {mem[int'(imem_addr)], mem[int'(imem_addr) + 1]};
    else
      imem_data = 16'hDEAD;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [15:0] m_pc, m_ii, m_ipc, m_epc;
  bit          m_iv, m_inh, m_halt, m_fault;

  task automatic m_reset();
    m_pc = 16'h0000; m_ii = 16'h0000; m_ipc = 16'h0000; m_iv = 0;
    m_epc = 16'h0000; m_inh = 0; m_halt = 0; m_fault = 0;
  endtask

  function automatic bit m_flush();
    return !m_halt && (exc_req || (eret && m_inh) || branch_taken);
  endfunction

  task automatic m_step();
    if (m_halt) return;
    if (exc_req && m_inh) begin
      m_halt = 1; m_ii = 16'h0000; m_iv = 0;
    end else if (exc_req) begin
      m_epc = exc_pc; m_inh = 1; m_pc = EXCV; m_ii = 16'h0000; m_iv = 0;
    end else if (eret && m_inh) begin
      m_pc = m_epc; m_inh = 0; m_ii = 16'h0000; m_iv = 0;
    end else if (branch_taken) begin
      m_pc = branch_target; m_ii = 16'h0000; m_iv = 0;
    end else if (stall) begin
      // hold
    end else if (m_pc[0] || int'(m_pc) + 1 >= MEMB) begin
      m_halt = 1; m_fault = 1; m_ii = 16'h0000; m_iv = 0;
    end else begin
      m_ii  = {mem[int'(m_pc)], mem[int'(m_pc) + 1]};
      m_ipc = m_pc; m_iv = 1; m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic chk_regs();
    chk("imem_addr", imem_addr, m_pc);
    chk("if_instr", if_instr, m_ii);
    chk("if_pc", if_pc, m_ipc);
    chk("if_valid", if_valid, m_iv);
    chk("epc", epc, m_epc);
    chk("in_handler", in_handler, m_inh);
    chk("halted", halted, m_halt);
    chk("fault", fault, m_fault);
  endtask

  // One clock cycle with the given inputs; called just after a rising edge.
  task automatic cyc(input bit s, input bit b, input logic [15:0] bt,
                     input bit e, input logic [15:0] ep, input bit er);
    stall = s; branch_taken = b; branch_target = bt;
    exc_req = e; exc_pc = ep; eret = er;
    #1;
    chk("flush", flush, m_flush());
    m_step();
    @(posedge clk);
    #1;
    chk_regs();
  endtask

  task automatic idle();
    cyc(0, 0, 16'h0, 0, 16'h0, 0);
  endtask

  // Asynchronous reset: outputs must clear before the next clock edge.
  task automatic do_reset();
    stall = 0; branch_taken = 0; branch_target = 0;
    exc_req = 0; exc_pc = 0; eret = 0;
    rst = 1'b1;
    #1;
    m_reset();
    chk_regs();
    chk("rst_flush", flush, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_regs();
  endtask

  initial begin
    int halt_cnt;
    logic [15:0] bt;
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h20; mem[2] = 8'h12;
    mem[3] = 8'hD1; mem[4] = 8'h14; mem[5] = 8'h8E;
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    // Sequential fetch and a two-cycle stall.
    idle();            chk("t_seq0", {if_instr, if_pc}, {16'h1120, 16'h0000});
    idle();            chk("t_seq1", {if_instr, if_pc}, {16'h12D1, 16'h0002});
    cyc(1, 0, 0, 0, 0, 0); chk("t_stall0", {if_instr, if_pc, imem_addr}, {16'h12D1, 16'h0002, 16'h0004});
    cyc(1, 0, 0, 0, 0, 0); chk("t_stall1", {if_instr, if_pc, imem_addr}, {16'h12D1, 16'h0002, 16'h0004});
    idle();            chk("t_seq2", {if_instr, if_pc, 15'h0, if_valid}, {16'h148E, 16'h0004, 16'h0001});

    // Branch at PC=6 to 0x14: bubble, then fetch from 0x14.
    stall = 0; exc_req = 0; eret = 0; branch_taken = 1; #1;
    chk("t_br_flush", flush, 1'b1);
    cyc(0, 1, 16'h0014, 0, 0, 0); chk("t_br_bubble", {if_instr, 15'h0, if_valid}, 32'h0);
    idle();            chk("t_br_pc", {if_pc, 15'h0, if_valid}, {16'h0014, 16'h0001});

    // Exception, handler fetch, return, then nested exception.
    cyc(0, 0, 0, 1, 16'h0030, 0); chk("t_exc", {epc, 15'h0, in_handler}, {16'h0030, 16'h0001});
    idle();            chk("t_vec", {if_pc, 15'h0, if_valid}, {16'h0040, 16'h0001});
    cyc(0, 0, 0, 0, 0, 1);
    idle();            chk("t_eret", {if_pc, 15'h0, in_handler}, {16'h0030, 16'h0000});
    cyc(0, 0, 0, 1, 16'h0032, 0);
    cyc(0, 0, 0, 1, 16'h0050, 0); chk("t_nest", {halted, fault}, 2'b10);
    idle();            chk("t_nest_hold", {imem_addr, epc}, {16'h0040, 16'h0032});

    // Reset while halted, then run off the end of memory.
    do_reset();
    cyc(0, 1, 16'h0060, 0, 0, 0);
    idle(); idle();    chk("t_last", {if_pc, 15'h0, if_valid}, {16'h0062, 16'h0001});
    idle();            chk("t_range", {halted, fault, if_valid}, 3'b110);
    idle();            chk("t_range_hold", {halted, fault, if_valid}, 3'b110);

    // Odd branch target faults when it becomes the PC.
    do_reset();
    cyc(0, 1, 16'h0003, 0, 0, 0); chk("t_odd_redirect", halted, 1'b0);
    idle();            chk("t_odd", {halted, fault, if_valid}, 3'b110);

    // Reset mid-stall.
    do_reset();
    idle(); idle();
    cyc(1, 0, 0, 0, 0, 0);
    do_reset();
    idle();            chk("t_restart", {if_instr, if_pc}, {16'h1120, 16'h0000});

    // Random traffic.
    halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_halt) halt_cnt++;
      if (halt_cnt > 4 || $urandom_range(0, 199) == 0) begin
        halt_cnt = 0;
        do_reset();
      end else begin
        bt = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 49) * 2);
        cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, bt,
            $urandom_range(0, 19) == 0, 16'($urandom_range(0, 49) * 2),
            $urandom_range(0, 7) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
